// File: rtl/id_banco_registros_if.sv
// Operand, write-back and debug-dump signals of the ID-stage register file.
// The master side drives the i_* signals; the register file (slave) drives the o_* signals.
interface id_banco_registros_if #(
    parameter int REGS    = 5,
    parameter int NB_DATA = 32
);
    logic               i_RegWrite;
    logic [REGS-1:0]    i_RD;
    logic [NB_DATA-1:0] i_DatoEscritura;
    logic [REGS-1:0]    i_RS;
    logic [REGS-1:0]    i_RT;
    logic [NB_DATA-1:0] o_DatoA;
    logic [NB_DATA-1:0] o_DatoB;
    logic               i_dump_start;
    logic               i_dbg_ready;
    logic               o_dbg_valid;
    logic [REGS-1:0]    o_dbg_idx;
    logic [NB_DATA-1:0] o_dbg_dato;
    logic               o_dbg_busy;
    logic               o_dbg_done;

    modport master (
        output i_RegWrite, i_RD, i_DatoEscritura, i_RS, i_RT, i_dump_start, i_dbg_ready,
        input  o_DatoA, o_DatoB, o_dbg_valid, o_dbg_idx, o_dbg_dato, o_dbg_busy, o_dbg_done
    );

    modport slave (
        input  i_RegWrite, i_RD, i_DatoEscritura, i_RS, i_RT, i_dump_start, i_dbg_ready,
        output o_DatoA, o_DatoB, o_dbg_valid, o_dbg_idx, o_dbg_dato, o_dbg_busy, o_dbg_done
    );
endinterface

// File: rtl/id_banco_registros.sv
// MIPS 32-entry register file with write-through read ports and a
// valid/ready debug engine that streams registers 0..31 in order.
module id_banco_registros #(
    parameter int REGS    = 5,
    parameter int NB_DATA = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    id_banco_registros_if.slave   bus
);
    localparam int               NREGS    = 2 ** REGS;
    localparam logic [REGS-1:0]  LAST_IDX = {REGS{1'b1}};
    localparam logic [REGS-1:0]  ZERO_IDX = {REGS{1'b0}};
    localparam logic [REGS-1:0]  ONE_IDX  = {{(REGS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [NB_DATA-1:0] regs_r [NREGS];
    state_t             state_r;
    state_t             state_s;
    logic [REGS-1:0]    idx_r;
    logic [REGS-1:0]    idx_s;
    logic               valid_r;
    logic               busy_r;
    logic               done_r;
    logic               wr_en_s;

    // Writes to register 0 are dropped, so it never leaves its reset value.
    assign wr_en_s = bus.i_RegWrite && (bus.i_RD != ZERO_IDX);

    // Register storage: cleared by reset, written by the WB stage.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {NB_DATA{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[bus.i_RD] <= bus.i_DatoEscritura;
        end else begin
            regs_r[bus.i_RD] <= regs_r[bus.i_RD];
        end
    end

    // Read paths see the data being written this cycle (WB/ID same-cycle hazard).
    always_comb begin
        bus.o_DatoA    = (wr_en_s && (bus.i_RD == bus.i_RS)) ? bus.i_DatoEscritura : regs_r[bus.i_RS];
        bus.o_DatoB    = (wr_en_s && (bus.i_RD == bus.i_RT)) ? bus.i_DatoEscritura : regs_r[bus.i_RT];
        bus.o_dbg_dato = (wr_en_s && (bus.i_RD == idx_r))    ? bus.i_DatoEscritura : regs_r[idx_r];
    end

    // Dump engine state, index and status flags.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= ST_IDLE;
            idx_r   <= ZERO_IDX;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            valid_r <= (state_s == ST_SEND);
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Dump engine next state; idx stops at the last entry instead of wrapping.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_dump_start) begin
                    state_s = ST_SEND;
                    idx_s   = ZERO_IDX;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (bus.i_dbg_ready && (idx_r == LAST_IDX)) begin
                    state_s = ST_DONE;
                end else if (bus.i_dbg_ready) begin
                    idx_s = idx_r + ONE_IDX;
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                idx_s   = ZERO_IDX;
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = ZERO_IDX;
            end
        endcase
    end

    assign bus.o_dbg_valid = valid_r;
    assign bus.o_dbg_busy  = busy_r;
    assign bus.o_dbg_done  = done_r;
    assign bus.o_dbg_idx   = idx_r;

endmodule

// File: tb/tb_id_banco_registros.sv
// Directed plus randomized bench for id_banco_registros, checked against
// an array model of the register file and the expected dump sequence.
module tb_id_banco_registros;
    logic i_clk;
    logic i_reset;
    int   n_tests;
    int   n_fail;
    logic [31:0] mdl [32];

    id_banco_registros_if #(.REGS(5), .NB_DATA(32)) bus ();

    id_banco_registros #(.REGS(5), .NB_DATA(32)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, applying the pending write to the model first.
    task automatic tick();
        if (bus.i_RegWrite && bus.i_RD != 5'd0) mdl[bus.i_RD] = bus.i_DatoEscritura;
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [31:0] expect_rd(input logic [4:0] a);
        if (bus.i_RegWrite && bus.i_RD != 5'd0 && bus.i_RD == a) return bus.i_DatoEscritura;
        else return mdl[a];
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(bus.o_dbg_valid), 32'd0);
        chk({tag, "_busy"},  32'(bus.o_dbg_busy),  32'd0);
        chk({tag, "_done"},  32'(bus.o_dbg_done),  32'd0);
        chk({tag, "_idx"},   32'(bus.o_dbg_idx),   32'd0);
        chk({tag, "_dato"},  bus.o_dbg_dato,       32'd0);
    endtask

    task automatic chk_send(input string tag, input int k);
        chk({tag, "_valid"}, 32'(bus.o_dbg_valid), 32'd1);
        chk({tag, "_busy"},  32'(bus.o_dbg_busy),  32'd1);
        chk({tag, "_idx"},   32'(bus.o_dbg_idx),   32'(k));
        chk({tag, "_dato"},  bus.o_dbg_dato,       expect_rd(5'(k)));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        i_reset = 1'b0;
        bus.i_RegWrite = 1'b0; bus.i_RD = 5'd0; bus.i_DatoEscritura = 32'd0;
        bus.i_RS = 5'd0; bus.i_RT = 5'd0; bus.i_dump_start = 1'b0; bus.i_dbg_ready = 1'b0;
        #12;
        chk_idle("rst");
        @(posedge i_clk); #2;
        i_reset = 1'b1;
        #1;
        bus.i_RS = 5'd5; bus.i_RT = 5'd31; #1;
        chk("rst_rd_a", bus.o_DatoA, 32'd0);
        chk("rst_rd_b", bus.o_DatoB, 32'd0);
        @(posedge i_clk); #1;

        // Write and read back, including the ignored write to register 0.
        bus.i_RegWrite = 1'b1; bus.i_RD = 5'd8; bus.i_DatoEscritura = 32'hDEADBEEF;
        tick();
        bus.i_RegWrite = 1'b0; bus.i_RS = 5'd8; #1;
        chk("wr8_rd", bus.o_DatoA, 32'hDEADBEEF);
        bus.i_RegWrite = 1'b1; bus.i_RD = 5'd0; bus.i_DatoEscritura = 32'h00001234; bus.i_RS = 5'd0; #1;
        chk("wr0_bypass", bus.o_DatoA, 32'd0);
        tick();
        bus.i_RegWrite = 1'b0; #1;
        chk("wr0_rd", bus.o_DatoA, 32'd0);

        // Write-through bypass on both ports.
        bus.i_RegWrite = 1'b1; bus.i_RD = 5'd9; bus.i_DatoEscritura = 32'h11;
        tick();
        bus.i_DatoEscritura = 32'h22; bus.i_RS = 5'd9; bus.i_RT = 5'd9; #1;
        chk("byp_a", bus.o_DatoA, 32'h22);
        chk("byp_b", bus.o_DatoB, 32'h22);
        bus.i_RegWrite = 1'b0; #1;
        chk("nobyp_a", bus.o_DatoA, 32'h11);
        chk("nobyp_b", bus.o_DatoB, 32'h11);
        tick();

        // Randomized writes and reads against the array model.
        for (int n = 0; n < 300; n++) begin
            bus.i_RegWrite      = 1'($urandom_range(1, 0));
            bus.i_RD            = 5'($urandom_range(31, 0));
            bus.i_DatoEscritura = $urandom;
            bus.i_RS            = (n % 4 == 0) ? bus.i_RD : 5'($urandom_range(31, 0));
            bus.i_RT            = 5'($urandom_range(31, 0));
            #1;
            chk("rnd_a", bus.o_DatoA, expect_rd(bus.i_RS));
            chk("rnd_b", bus.o_DatoB, expect_rd(bus.i_RT));
            tick();
        end

        // Full dump with ready held high.
        bus.i_RegWrite = 1'b1;
        for (int k = 1; k < 32; k++) begin
            bus.i_RD = 5'(k); bus.i_DatoEscritura = 32'h100 + 32'(k);
            tick();
        end
        bus.i_RegWrite = 1'b0; bus.i_RD = 5'd0;
        bus.i_dbg_ready = 1'b1; bus.i_dump_start = 1'b1; #1;
        chk_idle("pre_dump");
        tick();
        bus.i_dump_start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            chk_send("dump", k);
            chk("dump_seq", bus.o_dbg_dato, (k == 0) ? 32'd0 : 32'h100 + 32'(k));
            tick();
        end
        chk("done_pulse", 32'(bus.o_dbg_done),  32'd1);
        chk("done_valid", 32'(bus.o_dbg_valid), 32'd0);
        chk("done_busy",  32'(bus.o_dbg_busy),  32'd1);
        tick();
        chk_idle("post_dump");
        tick();
        chk("post_done2", 32'(bus.o_dbg_done), 32'd0);

        // Backpressure at idx 4 and an ignored restart request.
        bus.i_dump_start = 1'b1;
        tick();
        bus.i_dump_start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        bus.i_dbg_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_send("hold", 4);
            chk("hold_dato", bus.o_dbg_dato, 32'h104);
            tick();
        end
        chk_send("hold_end", 4);
        bus.i_dbg_ready = 1'b1; bus.i_dump_start = 1'b1;
        tick();
        bus.i_dump_start = 1'b0;
        chk_send("restart_ign", 5);
        chk("restart_dato", bus.o_dbg_dato, 32'h105);
        for (int k = 5; k < 10; k++) tick();
        chk_send("at10", 10);

        // Write to the presented register, then abort with reset at idx 20.
        bus.i_RegWrite = 1'b1; bus.i_RD = 5'd10; bus.i_DatoEscritura = 32'hABCD; #1;
        chk("wr_during_dump", bus.o_dbg_dato, 32'hABCD);
        tick();
        bus.i_RegWrite = 1'b0;
        for (int k = 11; k < 20; k++) tick();
        chk_send("at20", 20);
        #1;
        i_reset = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        #1;
        chk_idle("abort");
        #10;
        chk_idle("abort_hold");
        i_reset = 1'b1;
        for (int i = 0; i < 32; i += 7) begin
            bus.i_RS = 5'(i); bus.i_RT = 5'(31 - i); #1;
            chk("post_rst_a", bus.o_DatoA, 32'd0);
            chk("post_rst_b", bus.o_DatoB, 32'd0);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("no_done_after_abort", 32'(bus.o_dbg_done), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/id_banco_registros.md
Name: id_banco_registros

Overview:
- 32-entry general-purpose register file for the MIPS pipeline.
- The write port is driven by the WB stage: destination register, write data and RegWrite. The two asynchronous read ports feed the ID stage operands rs/rt.
- Includes a sequential debug-dump engine. It streams all registers, index 0 to 31, to the debug unit with a valid/ready handshake.

Parameters:
- REGS, 5, width of register index (2^REGS entries)
- NB_DATA, 32, register data width

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_RegWrite  in  1  WB write enable
- i_RD  in  REGS  WB destination register index
- i_DatoEscritura  in  NB_DATA  WB write data
- i_RS  in  REGS  read port A index
- i_RT  in  REGS  read port B index
- o_DatoA  out  NB_DATA  read port A data
- o_DatoB  out  NB_DATA  read port B data
- i_dump_start  in  1  one-cycle request to start a register dump
- i_dbg_ready  in  1  debug unit accepts current dump word
- o_dbg_valid  out  1  dump word valid
- o_dbg_idx  out  REGS  index of current dump word
- o_dbg_dato  out  NB_DATA  contents of register o_dbg_idx
- o_dbg_busy  out  1  dump in progress
- o_dbg_done  out  1  one-cycle pulse after last word accepted

Behaviour:

Reset (i_reset low, asynchronous):
- All 32 registers cleared to 0.
- State goes to IDLE.
- o_dbg_valid=0, o_dbg_idx=0, o_dbg_busy=0, o_dbg_done=0.
- o_dbg_dato reads register 0, i.e. 0.

Register 0:
- Always reads 0.
- Writes with i_RD=0 are ignored.

Write port:
- On rising i_clk, if i_RegWrite=1 and i_RD!=0, the register at i_RD takes i_DatoEscritura.

Read ports:
- Combinational, zero latency.
- Write-through bypass: if i_RegWrite=1, i_RD!=0 and i_RD==i_RS, then o_DatoA=i_DatoEscritura in the same cycle. Port B behaves identically with i_RT.
- This resolves the WB/ID same-cycle hazard. No extra forwarding is required for that distance.

Dump state machine, states IDLE, SEND, DONE:
- IDLE: o_dbg_valid=0, o_dbg_busy=0. i_dump_start=1 moves to SEND with idx=0.
- SEND: o_dbg_valid=1, o_dbg_busy=1. o_dbg_dato = register[idx], read through the same bypass as the read ports.
  - The word is held stable while i_dbg_ready=0.
  - On a clock edge with i_dbg_ready=1 and idx<31: idx increments.
  - On a clock edge with i_dbg_ready=1 and idx=31: go to DONE.
- DONE: lasts exactly one cycle with o_dbg_done=1, o_dbg_valid=0, o_dbg_busy=1, then returns to IDLE with idx=0.
- Latency: one cycle from i_dump_start to first o_dbg_valid. With ready held high, a full dump takes 32 cycles plus 1 done cycle.

Boundary cases:
- i_dump_start in SEND or DONE: ignored; no restart.
- i_dbg_ready while IDLE or DONE: ignored.
- WB writes continue during a dump. A write to the register currently presented is visible in o_dbg_dato in the same cycle. Registers already sent are not re-sent.
- Simultaneous i_dump_start and a WB write: both take effect.
- Reset mid-dump: aborts immediately to the reset state. No o_dbg_done pulse is issued.
- idx is REGS bits wide and never wraps within a dump, because the transition to DONE happens at 31.

Test Plan:
1. Reset, then read ports: release i_reset; i_RS=5, i_RT=31 -> o_DatoA=0, o_DatoB=0. Assert i_reset low mid-operation -> all outputs return to reset values asynchronously, before the next clock edge.
2. Write and read-back:
   - Write i_RD=8, data 0xDEADBEEF.
   - Next cycle, i_RS=8 -> o_DatoA=0xDEADBEEF.
   - Write i_RD=0, data 0x1234 -> reading register 0 gives 0.
3. Bypass:
   - Register 9 holds 0x11. In one cycle drive i_RegWrite=1, i_RD=9, data 0x22, i_RS=9, i_RT=9 -> o_DatoA=o_DatoB=0x22 before the edge.
   - Same stimulus with i_RegWrite=0 -> 0x11.
4. Full dump, ready always high:
   - Preload register k with 0x100+k for k=1..31; pulse i_dump_start.
   - Required: 32 consecutive valid cycles; idx 0..31; data 0, 0x101 .. 0x11F.
   - Then a single o_dbg_done pulse, then o_dbg_busy=0.
5. Backpressure and restart:
   - During a dump, hold i_dbg_ready=0 for 3 cycles at idx=4 -> idx/dato remain 4 / 0x104.
   - Pulse i_dump_start mid-dump -> ignored; sequence continues at idx 5.
6. Write during dump and abort:
   - While idx=10 is presented, WB writes 0xABCD to register 10 -> o_dbg_dato=0xABCD that cycle.
   - Assert reset at idx=20 -> o_dbg_valid=0, o_dbg_busy=0, no o_dbg_done; registers read 0 after reset.
